instr_fetch_seq: RTL and testbench

//  Upstream sequencer for the cpu core: fetches 16-bit instruction words from a synchronous

---
 rtl/instr_fetch_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_instr_fetch_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
//   Upstream sequencer for the cpu core. Starting at address 0, it fetches
//   16-bit instruction words from a synchronous instruction memory (one cycle
//   read latency) and hands each word to the core:
//     1. present the word on cpu_in,
//     2. pulse cpu_load,
//     3. hold cpu_s until the core drops cpu_w,
//     4. wait for cpu_w to rise again,
//     5. advance pc.
//   The run ends in HALTED on a HALT_WORD (that word is never issued) or after
//   the instruction at LAST_ADDR has executed. A watchdog moves the sequencer
//   to ERROR if the core spends WDOG_MAX cycles between START entry and
//   completion.
//
// Optional feature (compile-time macro SINGLE_STEP_EN):
//   Adds the input `step`. After each completed instruction the sequencer
//   parks in STEPWAIT (busy stays 1, pc held, watchdog idle) until step=1.
//   When the macro is undefined there is no step port and the sequencer
//   free-runs.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   start      in   1       begin a run at pc=0 (honoured in IDLE/HALTED/ERROR only)
//   step       in   1       (SINGLE_STEP_EN only) release STEPWAIT
//   mem_addr   out  ADDR_W  instruction memory address
//   mem_rdata  in   16      memory read data, valid one cycle after mem_addr
//   cpu_in     out  16      instruction word to the core
//   cpu_load   out  1       one-cycle load pulse to the core
//   cpu_s      out  1       start strobe to the core
//   cpu_w      in   1       core ready/idle flag (1 = ready)
//   pc         out  ADDR_W  address of the current instruction
//   busy       out  1       running (any state except IDLE/HALTED/ERROR)
//   halted     out  1       run finished normally
//   error      out  1       watchdog expired
// ---------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
  parameter logic [15:0]       HALT_WORD = 16'hE000,
  parameter int                WDOG_MAX  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       cpu_in,
  output logic              cpu_load,
  output logic              cpu_s,
  input  logic              cpu_w,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam int                WDOG_W    = $clog2(WDOG_MAX + 1);
  // The counter value at the start of the cycle in which it reaches WDOG_MAX.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);
  localparam logic [WDOG_W-1:0] WDOG_TOP  = WDOG_W'(WDOG_MAX);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_MEMWAIT,
    S_LOAD,
    S_START,
    S_EXEC,
    S_HALTED,
`ifdef SINGLE_STEP_EN
    S_STEPWAIT,
`endif
    S_ERROR
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [15:0]       cpu_in_reg, cpu_in_next;
  logic              cpu_load_reg, cpu_load_next;
  logic              cpu_s_reg, cpu_s_next;
  logic [WDOG_W-1:0] wdog_reg, wdog_next;

  logic [WDOG_W-1:0] wdog_inc;
  logic              wdog_expire;
  logic [ADDR_W-1:0] pc_plus1;

  // Saturating increment: the counter never wraps back to a "safe" value.
  assign wdog_inc    = (wdog_reg == WDOG_TOP) ? wdog_reg : wdog_reg + WDOG_W'(1);
  assign wdog_expire = (wdog_reg == WDOG_LAST);
  assign pc_plus1    = pc_reg + ADDR_W'(1);

  // -------------------------------------------------------------------------
  // State and registered outputs. reset is asynchronous, so cpu_s drops the
  // moment reset falls, not at the next clock edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      pc_reg       <= '0;
      mem_addr_reg <= '0;
      cpu_in_reg   <= '0;
      cpu_load_reg <= 1'b0;
      cpu_s_reg    <= 1'b0;
      wdog_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      mem_addr_reg <= mem_addr_next;
      cpu_in_reg   <= cpu_in_next;
      cpu_load_reg <= cpu_load_next;
      cpu_s_reg    <= cpu_s_next;
      wdog_reg     <= wdog_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic. mem_addr is loaded with the address to
  // fetch on the transition into FETCH, so the memory sees it during FETCH and
  // its data is available in MEMWAIT.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    mem_addr_next = mem_addr_reg;
    cpu_in_next   = cpu_in_reg;
    cpu_load_next = 1'b0;
    cpu_s_next    = cpu_s_reg;
    wdog_next     = wdog_reg;

    case (state_reg)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_next    = S_FETCH;
          pc_next       = '0;
          mem_addr_next = '0;
        end
      end

      S_FETCH: begin
        mem_addr_next = pc_reg;
        state_next    = S_MEMWAIT;
      end

      S_MEMWAIT: begin
        cpu_in_next = mem_rdata;
        if (mem_rdata == HALT_WORD) begin
          state_next = S_HALTED;
        end else begin
          state_next    = S_LOAD;
          cpu_load_next = 1'b1;
        end
      end

      S_LOAD: begin
        state_next = S_START;
        cpu_s_next = 1'b1;
        wdog_next  = '0;
      end

      // A core that still shows w=1 has not accepted yet: keep cpu_s high.
      S_START: begin
        wdog_next = wdog_inc;
        if (wdog_expire) begin
          state_next = S_ERROR;
          cpu_s_next = 1'b0;
        end else if (!cpu_w) begin
          state_next = S_EXEC;
          cpu_s_next = 1'b0;
        end
      end

      S_EXEC: begin
        wdog_next = wdog_inc;
        if (wdog_expire) begin
          state_next = S_ERROR;
        end else if (cpu_w) begin
          if (pc_reg == LAST_ADDR) begin
            state_next = S_HALTED;
          end else begin
`ifdef SINGLE_STEP_EN
            state_next    = S_STEPWAIT;
`else
            state_next    = S_FETCH;
            pc_next       = pc_plus1;
            mem_addr_next = pc_plus1;
`endif
          end
        end
      end

`ifdef SINGLE_STEP_EN
      S_STEPWAIT: begin
        if (step) begin
          state_next    = S_FETCH;
          pc_next       = pc_plus1;
          mem_addr_next = pc_plus1;
        end
      end
`endif

      default: begin
        state_next = S_IDLE;
        cpu_s_next = 1'b0;
      end
    endcase
  end

  assign mem_addr = mem_addr_reg;
  assign cpu_in   = cpu_in_reg;
  assign cpu_load = cpu_load_reg;
  assign cpu_s    = cpu_s_reg;
  assign pc       = pc_reg;

  // Status flags decode directly from the state register.
  assign halted = (state_reg == S_HALTED);
  assign error  = (state_reg == S_ERROR);
  assign busy   = (state_reg != S_IDLE) && (state_reg != S_HALTED) &&
                  (state_reg != S_ERROR);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_seq
//   Directed bench for instr_fetch_seq (LAST_ADDR overridden to 8'h02).
//   A transaction model derives, from the memory image and the run rules, the
//   ordered list of (pc, word) pairs the core must be loaded with and the
//   final pc. A compare process checks every cpu_load against that list each
//   cycle, plus load-to-strobe spacing and status exclusivity. Directed
//   sections add literal timing/value expectations.
//   Define SINGLE_STEP_EN to build and exercise the single-step variant.
// ---------------------------------------------------------------------------
module tb_instr_fetch_seq;

  localparam logic [7:0]  LAST = 8'h02;
  localparam logic [15:0] HALT = 16'hE000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        step;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic        cpu_s;
  logic        cpu_w;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        error;

  instr_fetch_seq #(
    .ADDR_W   (8),
    .LAST_ADDR(LAST),
    .HALT_WORD(HALT),
    .WDOG_MAX (64)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
`ifdef SINGLE_STEP_EN
    .step     (step),
`endif
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .cpu_in   (cpu_in),
    .cpu_load (cpu_load),
    .cpu_s    (cpu_s),
    .cpu_w    (cpu_w),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .error    (error)
  );

  int tests  = 0;
  int failed = 0;
  int load_cnt = 0;
  int core_mode = 1;          // 0: w stays 1, 1: normal core, 2: stuck core
  logic [7:0] exp_final_pc;
  logic [23:0] exp_q[$];      // {pc, word} expected on each cpu_load
  logic [15:0] mem [0:255];
  bit prev_load = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory, one-cycle read latency.
  initial mem_rdata = 16'h0000;
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    for (int i = 0; i < 256; i++) mem[i] = 16'h1234;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  // Transaction model: walk addresses 0..last; a HALT word ends the run
  // without being issued, otherwise the word is issued and the run ends
  // after address `last`.
  task automatic model_run(input int last);
    exp_q.delete();
    for (int a = 0; a <= last; a++) begin
      exp_final_pc = 8'(a);
      if (mem[a] == HALT) break;
      exp_q.push_back({8'(a), mem[a]});
    end
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Bounded wait: 0 cpu_s, 1 halted, 2 error, 3 load_cnt >= tgt.
  task automatic wait_sig(input int what, input int tgt, input int max_cyc,
                          input string name, output int n);
    bit hit = 0;
    n = 0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      n++;
      case (what)
        0: hit = cpu_s;
        1: hit = halted;
        2: hit = error;
        default: hit = (load_cnt >= tgt);
      endcase
    end
    if (!hit) begin
      tests++; failed++;
      $display("[TB] FAIL %s: timeout after %0d cycles, event not seen", name, n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check_eq({tag, "_cpu_in"},   32'(cpu_in),   0);
    check_eq({tag, "_cpu_load"}, 32'(cpu_load), 0);
    check_eq({tag, "_cpu_s"},    32'(cpu_s),    0);
    check_eq({tag, "_pc"},       32'(pc),       0);
    check_eq({tag, "_status"},   32'({busy, halted, error}), 0);
  endtask

  // Compare process: every load must match the next model transaction,
  // cpu_s must be high the cycle after a load, and at most one status flag.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_load) check_eq("s_after_load", 32'(cpu_s), 1);
      if (cpu_load) begin
        if (exp_q.size() == 0) begin
          tests++; failed++;
          $display("[TB] FAIL unexpected_load: pc=0x%0h word=0x%0h, no load expected", pc, cpu_in);
        end else begin
          check_eq("load_pc_word", 32'({pc, cpu_in}), 32'(exp_q.pop_front()));
        end
        load_cnt++;
      end
      check_eq("status_excl", 32'($countones({busy, halted, error}) <= 1), 1);
      prev_load = cpu_load;
    end else begin
      prev_load = 0;
    end
  end

  // Core model: on seeing cpu_s, drop w one cycle later; raise it three
  // cycles after that (mode 1) or never while stuck (mode 2).
  initial begin
    cpu_w = 1'b1;
    forever begin
      @(negedge clk);
      if (cpu_s && core_mode != 0) begin
        @(negedge clk); cpu_w = 1'b0;
        if (core_mode == 2) begin
          while (core_mode == 2) @(negedge clk);
        end else begin
          repeat (3) @(negedge clk);
        end
        cpu_w = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int base;
    rst_n = 1'b0; start = 1'b0; step = 1'b1;
    load_prog(16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 0);

    // Run + latency: MOV then HALT.
    load_prog(16'hD105, 16'hE000, 16'h0000, 16'h0000);
    model_run(LAST);
    base = load_cnt;
    start_pulse();                                  // now in cycle 1
    check_eq("c1_busy", 32'(busy), 1);
    check_eq("c1_mem_addr", 32'(mem_addr), 0);
    @(negedge clk);                                 // cycle 2
    check_eq("c2_load", 32'(cpu_load), 0);
    @(negedge clk);                                 // cycle 3
    check_eq("c3_load", 32'(cpu_load), 1);
    check_eq("c3_s", 32'(cpu_s), 0);
    check_eq("c3_cpu_in", 32'(cpu_in), 32'h0000D105);
    @(negedge clk);                                 // cycle 4
    check_eq("c4_s", 32'(cpu_s), 1);
    wait_sig(1, 0, 200, "run_halt", n);
    check_eq("run_halted", 32'(halted), 1);
    check_eq("run_pc", 32'(pc), 32'h01);
    check_eq("run_pc_model", 32'(pc), 32'(exp_final_pc));
    check_eq("run_loads", 32'(load_cnt - base), 1);
    check_eq("run_cpu_in", 32'(cpu_in), 32'h0000E000);
    check_eq("run_q_empty", 32'(exp_q.size()), 0);

    // LAST_ADDR end, with an ignored start while busy.
    load_prog(16'hD105, 16'hD203, 16'h6A40, 16'hD307);
    model_run(LAST);
    base = load_cnt;
    start_pulse();
    wait_sig(3, base + 2, 200, "last_second_load", n);
    check_eq("last_busy_mid", 32'(busy), 1);
    start_pulse();
    wait_sig(1, 0, 300, "last_halt", n);
    check_eq("last_halted", 32'(halted), 1);
    check_eq("last_pc", 32'(pc), 32'h02);
    check_eq("last_pc_model", 32'(pc), 32'(exp_final_pc));
    check_eq("last_loads", 32'(load_cnt - base), 3);
    check_eq("last_q_empty", 32'(exp_q.size()), 0);

    // Watchdog with a stuck core, then restart.
    load_prog(16'hD105, 16'hE000, 16'h0000, 16'h0000);
    exp_q.delete();
    exp_q.push_back({8'h00, 16'hD105});
    core_mode = 2;
    start_pulse();
    wait_sig(0, 0, 20, "wd_s_rise", n);
    wait_sig(2, 0, 100, "wd_error", n);
    check_eq("wd_cycles", 32'(n), 64);
    check_eq("wd_error", 32'(error), 1);
    check_eq("wd_s_low", 32'(cpu_s), 0);
    check_eq("wd_busy", 32'(busy), 0);
    core_mode = 1;
    repeat (3) @(negedge clk);
    check_eq("wd_error_holds", 32'(error), 1);
    model_run(LAST);
    start_pulse();
    check_eq("wd_restart_err", 32'(error), 0);
    check_eq("wd_restart_pc", 32'(pc), 0);
    wait_sig(1, 0, 200, "wd_restart_halt", n);
    check_eq("wd_restart_final_pc", 32'(pc), 32'(exp_final_pc));

    // Asynchronous reset while cpu_s is high.
    core_mode = 0;
    exp_q.delete();
    exp_q.push_back({8'h00, 16'hD105});
    start_pulse();
    wait_sig(0, 0, 20, "rst_s_rise", n);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_s_async", 32'(cpu_s), 0);
    check_eq("rst_busy_async", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    check_eq("rst_q_empty", 32'(exp_q.size()), 0);
    core_mode = 1;
    model_run(LAST);
    start_pulse();
    wait_sig(1, 0, 200, "rst_rerun_halt", n);
    check_eq("rst_rerun_pc", 32'(pc), 32'(exp_final_pc));

`ifdef SINGLE_STEP_EN
    // Single step: one instruction per step pulse, start ignored while parked.
    step = 1'b0;
    load_prog(16'hD105, 16'hD203, 16'h6A40, 16'h0000);
    model_run(LAST);
    base = load_cnt;
    start_pulse();
    repeat (15) @(negedge clk);
    check_eq("ss_loads1", 32'(load_cnt - base), 1);
    check_eq("ss_busy", 32'(busy), 1);
    check_eq("ss_pc1", 32'(pc), 0);
    start_pulse();
    repeat (10) @(negedge clk);
    check_eq("ss_loads1_hold", 32'(load_cnt - base), 1);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("ss_loads2", 32'(load_cnt - base), 2);
    check_eq("ss_pc2", 32'(pc), 1);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("ss_loads3", 32'(load_cnt - base), 3);
    check_eq("ss_halted", 32'(halted), 1);
    check_eq("ss_pc3", 32'(pc), 2);
    check_eq("ss_q_empty", 32'(exp_q.size()), 0);
    step = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
